// File: rtl/assembler_sequencer_pkg.sv
// ============================================================================
//  Module      : assembler_sequencer_pkg
//  Description : Shared types and constants for the two-pass assembler
//                sequencer: controller states, error codes, handshake
//                sub-phase and the PC step.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package assembler_sequencer_pkg;

    // Top-level controller state
    typedef enum logic [1:0] {
        IDLE                = 2'd0,
        PC_MAPPING          = 2'd1,
        INSTRUCTION_MAPPING = 2'd2,
        ERROR               = 2'd3
    } assembler_state_t;

    // Reason for entering ERROR
    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_PARSE    = 2'd1,
        ERR_OVERFLOW = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } asm_error_t;

    // Handshake sub-phase inside each pass
    typedef enum logic {
        PH_REQ  = 1'b0,
        PH_WAIT = 1'b1
    } asm_phase_t;

    // Byte distance between consecutive RV32 instructions
    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

`default_nettype wire

// File: rtl/assembler_watchdog.sv
// ============================================================================
//  Module      : assembler_watchdog
//  Description : Parser-response watchdog. Cleared while a request is issued,
//                counts every cycle spent waiting for the parser, and flags
//                expiry on the TIMEOUT-th waiting cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module assembler_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_count,
    output logic o_expire
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Counter update: clear on request, count while waiting, saturate at the limit
    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_count && (count_q <= C_LAST)) begin
            count_d = count_q + CW'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Expiry: this waiting cycle is the last one allowed without a response
    always_comb begin
        o_expire = i_count && (count_q == C_LAST);
    end

endmodule

`default_nettype wire

// File: rtl/assembler_sequencer.sv
// ============================================================================
//  Module      : assembler_sequencer
//  Description : Two-pass controller for the on-FPGA RISC-V assembler.
//                Pass 1 binds labels to PCs, pass 2 writes encoded
//                instructions into IMEM. One source line at a time is handed
//                to the parser over a req/done handshake.
//                Optional macro ASSEMBLER_TIMEOUT_EN adds a parser watchdog
//                (error code 3 after TIMEOUT waiting cycles).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module assembler_sequencer
    import assembler_sequencer_pkg::*;
#(
    parameter int LINE_AW = 10,
    parameter int IMEM_AW = 10,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   start_in,
    input  logic [LINE_AW-1:0]     num_lines_in,
    output logic                   parse_req_out,
    output logic [LINE_AW-1:0]     line_addr_out,
    output logic                   parse_pass_out,
    input  logic                   parse_done_in,
    input  logic                   parse_is_label_in,
    input  logic                   parse_is_inst_in,
    input  logic                   parse_error_in,
    input  logic [31:0]            inst_in,
    output logic                   label_we_out,
    output logic [31:0]            label_pc_out,
    output logic                   imem_we_out,
    output logic [IMEM_AW-1:0]     imem_addr_out,
    output logic [31:0]            imem_data_out,
    output assembler_state_t       state_out,
    output logic                   busy_out,
    output logic                   done_out,
    output logic [1:0]             error_code_out,
    output logic [LINE_AW-1:0]     error_line_out,
    output logic [IMEM_AW:0]       inst_count_out
);

    // Number of IMEM words, expressed in PC word units (pc[31:2])
    localparam logic [29:0] C_IMEM_WORDS = 30'(2 ** IMEM_AW);

    assembler_state_t      state_q,      state_d;
    asm_phase_t            phase_q,      phase_d;
    logic [LINE_AW-1:0]    line_q,       line_d;
    logic [LINE_AW-1:0]    num_lines_q,  num_lines_d;
    logic [31:0]           pc_q,         pc_d;
    asm_error_t            err_q,        err_d;
    logic [LINE_AW-1:0]    err_line_q,   err_line_d;
    logic [IMEM_AW:0]      inst_count_q, inst_count_d;
    logic                  label_we_q,   label_we_d;
    logic [31:0]           label_pc_q,   label_pc_d;
    logic                  imem_we_q,    imem_we_d;
    logic [IMEM_AW-1:0]    imem_addr_q,  imem_addr_d;
    logic [31:0]           imem_data_q,  imem_data_d;
    logic                  done_q,       done_d;

    logic                  busy;
    logic                  in_req;
    logic                  in_wait;
    logic                  last_line;
    logic                  pc_full;
    logic [31:0]           pc_next;
    logic                  timeout_hit;

    assign busy      = (state_q == PC_MAPPING) || (state_q == INSTRUCTION_MAPPING);
    assign in_req    = busy && (phase_q == PH_REQ);
    assign in_wait   = busy && (phase_q == PH_WAIT);
    assign last_line = (line_q == (num_lines_q - LINE_AW'(1)));
    // Another instruction would push the count past IMEM capacity
    assign pc_full   = (pc_q[31:2] >= C_IMEM_WORDS);

`ifdef ASSEMBLER_TIMEOUT_EN
    assembler_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk_in),
        .rst      (rst_in),
        .i_clear  (in_req),
        .i_count  (in_wait && !parse_done_in),
        .o_expire (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    // State and datapath registers, synchronous reset to the idle values
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= IDLE;
            phase_q      <= PH_REQ;
            line_q       <= '0;
            num_lines_q  <= '0;
            pc_q         <= '0;
            err_q        <= ERR_NONE;
            err_line_q   <= '0;
            inst_count_q <= '0;
            label_we_q   <= 1'b0;
            label_pc_q   <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_data_q  <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            line_q       <= line_d;
            num_lines_q  <= num_lines_d;
            pc_q         <= pc_d;
            err_q        <= err_d;
            err_line_q   <= err_line_d;
            inst_count_q <= inst_count_d;
            label_we_q   <= label_we_d;
            label_pc_q   <= label_pc_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_data_q  <= imem_data_d;
            done_q       <= done_d;
        end
    end

    // Next-state logic: pass sequencing, line/PC bookkeeping and strobe set-up
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        line_d       = line_q;
        num_lines_d  = num_lines_q;
        pc_d         = pc_q;
        err_d        = err_q;
        err_line_d   = err_line_q;
        inst_count_d = inst_count_q;
        label_we_d   = 1'b0;
        label_pc_d   = label_pc_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_data_d  = imem_data_q;
        done_d       = 1'b0;
        pc_next      = parse_is_inst_in ? (pc_q + PC_STEP) : pc_q;

        case (state_q)
            IDLE, ERROR: begin
                if (start_in) begin
                    err_d        = ERR_NONE;
                    err_line_d   = '0;
                    inst_count_d = '0;
                    if (num_lines_in == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = PC_MAPPING;
                        phase_d     = PH_REQ;
                        line_d      = '0;
                        pc_d        = '0;
                        num_lines_d = num_lines_in;
                    end
                end
            end

            PC_MAPPING, INSTRUCTION_MAPPING: begin
                if (phase_q == PH_REQ) begin
                    phase_d = PH_WAIT;
                end else if (parse_done_in) begin
                    if (parse_error_in) begin
                        state_d    = ERROR;
                        err_d      = ERR_PARSE;
                        err_line_d = line_q;
                    end else if (state_q == PC_MAPPING) begin
                        if (parse_is_inst_in && pc_full) begin
                            state_d    = ERROR;
                            err_d      = ERR_OVERFLOW;
                            err_line_d = line_q;
                        end else begin
                            // Label binds to the PC before this line's instruction
                            if (parse_is_label_in) begin
                                label_we_d = 1'b1;
                                label_pc_d = pc_q;
                            end
                            phase_d = PH_REQ;
                            if (last_line) begin
                                inst_count_d = pc_next[IMEM_AW+2:2];
                                state_d      = INSTRUCTION_MAPPING;
                                line_d       = '0;
                                pc_d         = '0;
                            end else begin
                                line_d = line_q + LINE_AW'(1);
                                pc_d   = pc_next;
                            end
                        end
                    end else begin
                        if (parse_is_inst_in) begin
                            imem_we_d   = 1'b1;
                            imem_addr_d = pc_q[IMEM_AW+1:2];
                            imem_data_d = inst_in;
                            pc_d        = pc_next;
                        end
                        if (last_line) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            line_d  = line_q + LINE_AW'(1);
                            phase_d = PH_REQ;
                        end
                    end
                end else if (timeout_hit) begin
                    state_d    = ERROR;
                    err_d      = ERR_TIMEOUT;
                    err_line_d = line_q;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the registered state
    always_comb begin
        parse_req_out  = in_req;
        line_addr_out  = line_q;
        parse_pass_out = (state_q == INSTRUCTION_MAPPING);
        label_we_out   = label_we_q;
        label_pc_out   = label_pc_q;
        imem_we_out    = imem_we_q;
        imem_addr_out  = imem_addr_q;
        imem_data_out  = imem_data_q;
        state_out      = state_q;
        busy_out       = busy;
        done_out       = done_q;
        error_code_out = err_q;
        error_line_out = err_line_q;
        inst_count_out = inst_count_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_assembler_sequencer.sv
`timescale 1ns/1ps
`default_nettype none

module tb_assembler_sequencer;
    import assembler_sequencer_pkg::*;

    localparam int LINE_AW = 4;
    localparam int IMEM_AW = 2;
    localparam int TIMEOUT = 16;

    logic                 clk_in = 1'b0;
    logic                 rst_in;
    logic                 start_in;
    logic [LINE_AW-1:0]   num_lines_in;
    logic                 parse_req_out;
    logic [LINE_AW-1:0]   line_addr_out;
    logic                 parse_pass_out;
    logic                 parse_done_in;
    logic                 parse_is_label_in;
    logic                 parse_is_inst_in;
    logic                 parse_error_in;
    logic [31:0]          inst_in;
    logic                 label_we_out;
    logic [31:0]          label_pc_out;
    logic                 imem_we_out;
    logic [IMEM_AW-1:0]   imem_addr_out;
    logic [31:0]          imem_data_out;
    assembler_state_t     state_out;
    logic                 busy_out;
    logic                 done_out;
    logic [1:0]           error_code_out;
    logic [LINE_AW-1:0]   error_line_out;
    logic [IMEM_AW:0]     inst_count_out;

    assembler_sequencer #(
        .LINE_AW (LINE_AW),
        .IMEM_AW (IMEM_AW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .start_in          (start_in),
        .num_lines_in      (num_lines_in),
        .parse_req_out     (parse_req_out),
        .line_addr_out     (line_addr_out),
        .parse_pass_out    (parse_pass_out),
        .parse_done_in     (parse_done_in),
        .parse_is_label_in (parse_is_label_in),
        .parse_is_inst_in  (parse_is_inst_in),
        .parse_error_in    (parse_error_in),
        .inst_in           (inst_in),
        .label_we_out      (label_we_out),
        .label_pc_out      (label_pc_out),
        .imem_we_out       (imem_we_out),
        .imem_addr_out     (imem_addr_out),
        .imem_data_out     (imem_data_out),
        .state_out         (state_out),
        .busy_out          (busy_out),
        .done_out          (done_out),
        .error_code_out    (error_code_out),
        .error_line_out    (error_line_out),
        .inst_count_out    (inst_count_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int                num_lines;
        logic [7:0]        label_mask;
        logic [7:0]        inst_mask;
        bit                err_en;
        bit                err_pass;
        int                err_line;
        logic [7:0][31:0]  insts;
        assembler_state_t  exp_state;
        int                exp_code;
        int                exp_err_line;
        int                exp_count;     // -1: not checked
        int                exp_done;
    } vec_t;

    typedef struct {
        bit          is_imem;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t   exp_q[$];
    vec_t  cur;
    vec_t  vecs[9];
    bit    stub_en = 1'b1;
    int    tests   = 0;
    int    fails   = 0;
    int    req_cnt = 0;
    int    done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int n, input logic [7:0] lm, input logic [7:0] im,
                                input bit ee, input bit ep, input int el,
                                input assembler_state_t es, input int ec, input int eel,
                                input int cnt, input int dn);
        vec_t v;
        v.num_lines = n;   v.label_mask = lm;  v.inst_mask = im;
        v.err_en = ee;     v.err_pass = ep;    v.err_line = el;
        for (int i = 0; i < 8; i++) v.insts[i] = 32'h1000_0013 + 32'(i) * 32'h100;
        v.exp_state = es;  v.exp_code = ec;    v.exp_err_line = eel;
        v.exp_count = cnt; v.exp_done = dn;
        return v;
    endfunction

    // Reference model: expected label/IMEM write stream for one program
    task automatic push_model(input vec_t v);
        int pc  = 0;
        bit stop = 1'b0;
        for (int l = 0; l < v.num_lines && !stop; l++) begin
            if (v.err_en && !v.err_pass && v.err_line == l) stop = 1'b1;
            else if (v.inst_mask[l] && (pc / 4 + 1 > (1 << IMEM_AW))) stop = 1'b1;
            else begin
                if (v.label_mask[l]) exp_q.push_back('{1'b0, 32'(pc), 32'h0});
                if (v.inst_mask[l]) pc += 4;
            end
        end
        pc = 0;
        for (int l = 0; l < v.num_lines && !stop; l++) begin
            if (v.err_en && v.err_pass && v.err_line == l) stop = 1'b1;
            else if (v.inst_mask[l]) begin
                exp_q.push_back('{1'b1, 32'(pc / 4), v.insts[l]});
                pc += 4;
            end
        end
    endtask

    // Parser stub: answers each request one cycle later from the current program
    initial begin
        forever begin
            @(negedge clk_in);
            if (stub_en && parse_req_out) begin
                int l;
                bit p;
                l = int'(line_addr_out);
                p = parse_pass_out;
                @(posedge clk_in); #1;
                parse_done_in     = 1'b1;
                parse_is_label_in = cur.label_mask[l];
                parse_is_inst_in  = cur.inst_mask[l];
                parse_error_in    = cur.err_en && (cur.err_pass == p) && (cur.err_line == l);
                inst_in           = p ? cur.insts[l] : 32'hDEAD_BEEF;
                @(posedge clk_in); #1;
                parse_done_in     = 1'b0;
                parse_is_label_in = 1'b0;
                parse_is_inst_in  = 1'b0;
                parse_error_in    = 1'b0;
                inst_in           = 32'h0;
            end
        end
    end

    task automatic sb_check(input bit kind, input logic [31:0] addr, input logic [31:0] data);
        wr_t e;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write: got kind %0d addr 0x%0h data 0x%0h expected none", kind, addr, data);
        end else begin
            e = exp_q.pop_front();
            check("wr_kind", {31'b0, kind}, {31'b0, e.is_imem});
            check("wr_addr", addr, e.addr);
            if (kind) check("wr_data", data, e.data);
        end
    endtask

    // Monitor: scoreboard writes and count pulses away from the active edge
    always @(negedge clk_in) begin
        if (parse_req_out) req_cnt++;
        if (done_out) done_cnt++;
        if (label_we_out) sb_check(1'b0, label_pc_out, 32'h0);
        if (imem_we_out) sb_check(1'b1, 32'(imem_addr_out), imem_data_out);
    end

    task automatic pulse_start(input int n);
        @(posedge clk_in); #1;
        start_in     = 1'b1;
        num_lines_in = LINE_AW'(n);
        @(posedge clk_in); #1;
        start_in     = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int cyc = 0;
        while (busy_out && cyc < 400) begin
            @(posedge clk_in); #1;
            cyc++;
        end
        check(name, {31'b0, busy_out}, 32'h0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int req0, done0;
        cur   = v;
        req0  = req_cnt;
        done0 = done_cnt;
        push_model(v);
        pulse_start(v.num_lines);
        check($sformatf("v%0d_first_state", idx), 32'(state_out),
              32'((v.num_lines == 0) ? IDLE : PC_MAPPING));
        if (v.num_lines == 0) check($sformatf("v%0d_zero_done", idx), {31'b0, done_out}, 32'h1);
        wait_idle($sformatf("v%0d_finish", idx));
        repeat (2) @(posedge clk_in);
        #1;
        check($sformatf("v%0d_state", idx), 32'(state_out), 32'(v.exp_state));
        check($sformatf("v%0d_code", idx), 32'(error_code_out), 32'(v.exp_code));
        if (v.exp_code != 0) check($sformatf("v%0d_err_line", idx), 32'(error_line_out), 32'(v.exp_err_line));
        if (v.exp_count >= 0) check($sformatf("v%0d_count", idx), 32'(inst_count_out), 32'(v.exp_count));
        check($sformatf("v%0d_done_pulses", idx), 32'(done_cnt - done0), 32'(v.exp_done));
        check($sformatf("v%0d_pending_writes", idx), 32'(exp_q.size()), 32'h0);
        if (v.num_lines == 0) check($sformatf("v%0d_no_req", idx), 32'(req_cnt - req0), 32'h0);
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        int cyc;
        int req0, done0;

        // Program vectors: {lines, label mask, inst mask, error, expected result}
        vecs[0] = mk(3, 8'b001, 8'b110, 0, 0, 0, IDLE, 0, 0, 2, 1);
        vecs[0].insts[1] = 32'h0010_0093;
        vecs[0].insts[2] = 32'hFFDF_F06F;
        vecs[1] = vecs[0];
        vecs[1].err_en = 1'b1; vecs[1].err_pass = 1'b1; vecs[1].err_line = 1;
        vecs[1].exp_state = ERROR; vecs[1].exp_code = 1; vecs[1].exp_err_line = 1;
        vecs[1].exp_done = 0;
        vecs[2] = vecs[0];
        vecs[3] = mk(5, 8'b00000, 8'b11111, 0, 0, 0, ERROR, 2, 4, -1, 0);
        vecs[4] = mk(0, 8'b0, 8'b0, 0, 0, 0, IDLE, 0, 0, 0, 1);
        vecs[5] = mk(4, 8'b0101, 8'b1011, 0, 0, 0, IDLE, 0, 0, 3, 1);
        vecs[6] = mk(4, 8'b0011, 8'b0011, 1, 0, 2, ERROR, 1, 2, -1, 0);
        vecs[7] = mk(4, 8'b0000, 8'b1111, 0, 0, 0, IDLE, 0, 0, 4, 1);
        vecs[8] = mk(2, 8'b00, 8'b11, 1, 1, 0, ERROR, 1, 0, 2, 0);

        cur = vecs[0];
        rst_in = 1'b1; start_in = 1'b0; num_lines_in = '0;
        parse_done_in = 1'b0; parse_is_label_in = 1'b0; parse_is_inst_in = 1'b0;
        parse_error_in = 1'b0; inst_in = 32'h0;
        repeat (3) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        check("reset_state", 32'(state_out), 32'(IDLE));
        check("reset_strobes", {26'b0, parse_req_out, label_we_out, imem_we_out, done_out, busy_out, parse_pass_out}, 32'h0);
        check("reset_misc", {15'b0, error_code_out, error_line_out, inst_count_out, imem_addr_out, line_addr_out}, 32'h0);

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // start_in while busy must not disturb the running program
        cur   = vecs[0];
        req0  = req_cnt;
        done0 = done_cnt;
        push_model(vecs[0]);
        pulse_start(3);
        repeat (3) @(posedge clk_in);
        #1;
        start_in = 1'b1; num_lines_in = LINE_AW'(1);
        @(posedge clk_in); #1;
        start_in = 1'b0;
        wait_idle("busy_start_finish");
        repeat (2) @(posedge clk_in);
        #1;
        check("busy_start_reqs", 32'(req_cnt - req0), 32'd6);
        check("busy_start_count", 32'(inst_count_out), 32'd2);
        check("busy_start_done", 32'(done_cnt - done0), 32'd1);
        check("busy_start_writes", 32'(exp_q.size()), 32'h0);
        exp_q.delete();

        // Reset while an IMEM write is about to be issued in pass 2
        cur = vecs[0];
        push_model(vecs[0]);
        pulse_start(3);
        cyc = 0;
        while (!(parse_pass_out && parse_done_in && line_addr_out == LINE_AW'(1)) && cyc < 200) begin
            @(negedge clk_in);
            cyc++;
        end
        check("rst_mid_found", {31'b0, parse_pass_out && parse_done_in}, 32'h1);
        rst_in = 1'b1;
        exp_q.delete();
        @(negedge clk_in);
        check("rst_mid_state", 32'(state_out), 32'(IDLE));
        check("rst_mid_strobes", {26'b0, parse_req_out, label_we_out, imem_we_out, done_out, busy_out, parse_pass_out}, 32'h0);
        check("rst_mid_misc", {15'b0, error_code_out, error_line_out, inst_count_out, imem_addr_out, line_addr_out}, 32'h0);
        check("rst_mid_data", imem_data_out | label_pc_out, 32'h0);
        rst_in = 1'b0;
        repeat (4) @(posedge clk_in);

        // Parser never answers line 0
        stub_en = 1'b0;
        pulse_start(1);
        check("to_req", {31'b0, parse_req_out}, 32'h1);
        @(posedge clk_in);
`ifdef ASSEMBLER_TIMEOUT_EN
        repeat (15) @(posedge clk_in);
        #1;
        check("to_before_expiry", 32'(state_out), 32'(PC_MAPPING));
        @(posedge clk_in); #1;
        check("to_state", 32'(state_out), 32'(ERROR));
        check("to_code", 32'(error_code_out), 32'd3);
        check("to_line", 32'(error_line_out), 32'd0);
`else
        repeat (1000) @(posedge clk_in);
        #1;
        check("to_still_waiting", 32'(state_out), 32'(PC_MAPPING));
        check("to_no_rereq", {30'b0, parse_req_out, busy_out}, 32'h1);
        check("to_code_none", 32'(error_code_out), 32'd0);
`endif
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        rst_in  = 1'b0;
        stub_en = 1'b1;
        repeat (2) @(posedge clk_in);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/assembler_sequencer.md
Name: assembler_sequencer

Overview:
- Top-level two-pass controller for the on-FPGA RISC-V assembler. Walks the source-line buffer twice and steps through the assembler_state_t states IDLE, PC_MAPPING, INSTRUCTION_MAPPING and ERROR.
- Hands one line at a time to the line parser over a req/done handshake.
- Pass 1: assigns PCs to labels. Pass 2: writes encoded instructions into instruction memory.
- Sits between the text-buffer/UART loader and the parser, label table and IMEM.

Parameters:
- LINE_AW, 10, width of line index and line count.
- IMEM_AW, 10, IMEM word-address width; capacity is 2**IMEM_AW instructions.
- TIMEOUT, 1024, watchdog limit in cycles, used only with the optional feature.

Ports:
- clk_in, input, 1, system clock.
- rst_in, input, 1, synchronous active-high reset.
- start_in, input, 1, one-cycle start pulse.
- num_lines_in, input, LINE_AW, number of source lines; sampled on accepted start.
- parse_req_out, output, 1, one-cycle request to parse line line_addr_out.
- line_addr_out, output, LINE_AW, current line index.
- parse_pass_out, output, 1, 0 = PC_MAPPING, 1 = INSTRUCTION_MAPPING.
- parse_done_in, input, 1, parser result valid (one-cycle pulse).
- parse_is_label_in, input, 1, line defines a label.
- parse_is_inst_in, input, 1, line contains an instruction.
- parse_error_in, input, 1, syntax error or unknown label.
- inst_in, input, 32, encoded instruction (pass 2 only).
- label_we_out, output, 1, label-table write strobe.
- label_pc_out, output, 32, PC bound to the label.
- imem_we_out, output, 1, IMEM write strobe.
- imem_addr_out, output, IMEM_AW, IMEM word address.
- imem_data_out, output, 32, instruction word.
- state_out, output, assembler_state_t, current state.
- busy_out, output, 1, high in PC_MAPPING or INSTRUCTION_MAPPING.
- done_out, output, 1, one-cycle pulse on successful completion.
- error_code_out, output, 2, 0 none, 1 parse, 2 overflow, 3 timeout.
- error_line_out, output, LINE_AW, line index at which the error occurred.
- inst_count_out, output, IMEM_AW+1, instructions counted in pass 1.

Behaviour:
- Reset: state IDLE; all strobes 0; all outputs 0; error_code 0; internal line index and PC cleared.
- Internal sub-phase inside each pass:
  - REQ: parse_req_out = 1 for exactly one cycle.
  - WAIT: hold until parse_done_in.
- Parser response: parse_done_in is honoured only in WAIT and ignored in every other phase. The earliest legal done is the cycle after REQ, so the minimum is 2 cycles per line.
- IDLE / ERROR + start_in:
  - If num_lines_in == 0: stay in IDLE, pulse done_out the next cycle, inst_count_out = 0.
  - Otherwise: go to PC_MAPPING/REQ with line = 0, pc = 0, error_code cleared.
  - start_in while busy is ignored.
- PC_MAPPING, on done:
  - Error: parse_error -> ERROR (code 1).
  - Label: is_label -> label_we_out pulses the next cycle with label_pc_out = current pc, taken before any increment on the same line.
  - Instruction: is_inst -> pc += 4.
  - Overflow: if pc/4 would exceed 2**IMEM_AW -> ERROR (code 2).
  - Advance: if line == num_lines-1, latch inst_count = pc/4 and go to INSTRUCTION_MAPPING/REQ with line = 0, pc = 0. Otherwise line+1 and REQ.
- INSTRUCTION_MAPPING, on done:
  - Error: parse_error -> ERROR (code 1).
  - Instruction: is_inst -> imem_we_out pulses the next cycle with imem_addr_out = pc[IMEM_AW+1:2] and imem_data_out = inst_in; then pc += 4.
  - Last line: go to IDLE and pulse done_out in the same cycle as the final write (if any).
- Write-strobe alignment: label_we_out and imem_we_out are registered and last one cycle. Address and data are stable while the strobe is high.
- ERROR:
  - error_line_out = the offending line.
  - No further strobes are issued.
  - The state is sticky; leave only via start_in (restart) or rst_in.
- Reset mid-pass: aborts immediately to the reset values. A pending strobe is dropped.
- PC arithmetic: 32-bit and always word aligned.

Optional Feature:
- Macro: ASSEMBLER_TIMEOUT_EN.
- Enabled: a counter is cleared on REQ and counts in WAIT. On reaching TIMEOUT without parse_done_in, go to ERROR with code 3 and error_line = current line.
- Disabled: no counter; WAIT holds indefinitely and code 3 is never produced.

Decomposition:
- Shared package gets:
  - assembler_state_t (reused).
  - New typedef asm_error_t {ERR_NONE, ERR_PARSE, ERR_OVERFLOW, ERR_TIMEOUT}.
  - Constant PC_STEP = 4.
- Sub-module assembler_watchdog (counter plus expire flag) is instantiated only under ASSEMBLER_TIMEOUT_EN.

Test Plan:
- Three lines: label "loop:", "addi x1,x0,1", "jal x0,loop"; parser stub returns done 1 cycle after req; pass 2 inst_in 0x00100093 and 0xFFDFF06F -> expect:
  - label_we once with pc = 0;
  - IMEM[0] = 0x00100093, IMEM[1] = 0xFFDFF06F;
  - inst_count_out = 2; one done_out pulse.
- parse_error_in on line 1 of pass 2 -> state ERROR, error_code = 1, error_line = 1, no IMEM write for line 1; a following start_in restarts in PC_MAPPING.
- IMEM_AW = 2 with 5 instruction lines -> ERROR code 2 at line 4 during PC_MAPPING; zero imem_we pulses.
- num_lines_in = 0 -> done_out one cycle after start, state stays IDLE, no parse_req; start_in asserted while busy has no effect on line/pc.
- With ASSEMBLER_TIMEOUT_EN and TIMEOUT = 16, parser never answers line 0 -> ERROR code 3 exactly 16 cycles after WAIT entry; without the macro, still in WAIT after 1000 cycles.
- rst_in asserted mid pass 2 -> next cycle: IDLE, all outputs 0, no strobe.
